// File: rtl/mvb_tx_pkg.sv
// Shared types and line constants for the MVB Manchester transmitter.
// Delimiter patterns are stored as half-bit sequences, MSB first.
package mvb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_DEL,
        DATA,
        END_DEL,
        DONE
    } state_t;

    localparam int          SD_HB      = 18;
    localparam logic [17:0] MASTER_SD  = 18'b10_11_00_01_11_00_01_01_01;
    localparam logic [17:0] SLAVE_SD   = 18'b10_10_10_10_00_11_01_00_11;
    localparam logic [1:0]  END_DEL_HB = 2'b00;

    function automatic logic sd_half(input logic master, input logic [4:0] idx);
        logic [17:0] sd;
        sd = master ? MASTER_SD : SLAVE_SD;
        sd = sd << idx;
        return sd[17];
    endfunction

endpackage

// File: rtl/mvb_halfbit_timer.sv
// Half-bit timer: free-running modulo counter with synchronous clear.
// hb_end marks the last clk of each half-bit.
module mvb_halfbit_timer #(
    parameter int HALF_BIT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic hb_end
);

    localparam int CW = $clog2(HALF_BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign hb_end = (cnt == LAST);

endmodule

// File: rtl/mvb_manchester_tx.sv
// MVB line stage: start delimiter, Manchester data and end delimiter
// onto the transceiver pins, pulling bits through a one-clk strobe.
module mvb_manchester_tx
    import mvb_tx_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    input  logic master_frame,
    input  logic bit_data,
    input  logic bit_valid,
    input  logic bit_last,
    output logic bit_ready,
    output logic line_out,
    output logic line_en,
    output logic busy,
    output logic frame_done,
    output logic underrun
);

    state_t     state, state_n;
    logic [4:0] idx;
    logic       master_q;
    logic       data_q;
    logic       last_q;
    logic       und_q;
    logic       hb_end;
    logic       accept;
    logic       strobe;

    mvb_halfbit_timer #(
        .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .hb_end(hb_end)
    );

    assign accept = (state == IDLE) && frame_start;

    // Pull a new bit after the delimiter and after every non-final bit
    assign strobe = hb_end &&
                    (((state == START_DEL) && (idx == 5'(SD_HB - 1))) ||
                     ((state == DATA) && idx[0] && !last_q));

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:
                if (frame_start)
                    state_n = START_DEL;
            START_DEL:
                if (strobe)
                    state_n = bit_valid ? DATA : END_DEL;
            DATA:
                if (hb_end && idx[0]) begin
                    if (last_q || !bit_valid)
                        state_n = END_DEL;
                end
            END_DEL:
                if (hb_end && idx[0])
                    state_n = DONE;
            DONE:
                state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx      <= '0;
            master_q <= 1'b0;
            data_q   <= 1'b0;
            last_q   <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            if (accept) begin
                idx      <= '0;
                master_q <= master_frame;
                last_q   <= 1'b0;
                und_q    <= 1'b0;
            end else if (hb_end && state != IDLE) begin
                if (state_n != state || (state == DATA && idx[0]))
                    idx <= '0;
                else
                    idx <= idx + 5'd1;
            end
            if (strobe) begin
                if (bit_valid) begin
                    data_q <= bit_data;
                    last_q <= bit_last;
                end else begin
                    und_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        line_en    = 1'b0;
        line_out   = 1'b0;
        busy       = (state != IDLE);
        frame_done = (state == DONE);
        bit_ready  = strobe;
        underrun   = und_q;
        unique case (state)
            START_DEL: begin
                line_en  = 1'b1;
                line_out = sd_half(master_q, idx);
            end
            DATA: begin
                line_en  = 1'b1;
                line_out = idx[0] ? ~data_q : data_q;
            end
            END_DEL: begin
                line_en  = 1'b1;
                line_out = idx[0] ? END_DEL_HB[0] : END_DEL_HB[1];
            end
            default: begin
                line_en  = 1'b0;
                line_out = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mvb_manchester_tx.sv
// Bench for mvb_manchester_tx: frame table plus random frames, checked
// cycle by cycle against a half-bit list built from the line rules.
module tb_mvb_manchester_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_start = 1'b0;
    logic master_frame = 1'b0;
    logic bit_data = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_last = 1'b0;
    logic bit_ready, line_out, line_en, busy, frame_done, underrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mvb_manchester_tx #(.HALF_BIT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .master_frame(master_frame),
        .bit_data    (bit_data),
        .bit_valid   (bit_valid),
        .bit_last    (bit_last),
        .bit_ready   (bit_ready),
        .line_out    (line_out),
        .line_en     (line_en),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    typedef struct {
        bit          master;
        int          n;
        logic [31:0] d;
        int          avail;
        int          pulse_at;
        int          rst_at;
        int          exp_done;
        string       name;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [5:0] outs();
        return {line_en, line_out, bit_ready, frame_done, busy, underrun};
    endfunction

    task automatic chk(input string name, input int i,
                       input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d {en,out,rdy,done,busy,und} got=%b want=%b",
                     name, i, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        logic [17:0] sd;
        logic        hb[$];
        bit          und;
        int          nb, done_i, nstrobe, ptr, first_done, sidx;
        logic [5:0]  e;
        bit          is_str;

        und = (v.avail < v.n);
        nb  = und ? v.avail : v.n;
        sd  = v.master ? 18'b101100011100010101 : 18'b101010100011010011;
        hb  = {};
        for (int k = 17; k >= 0; k--) hb.push_back(sd[k]);
        for (int j = 0; j < nb; j++) begin
            hb.push_back(v.d[v.n-1-j]);
            hb.push_back(!v.d[v.n-1-j]);
        end
        hb.push_back(1'b0);
        hb.push_back(1'b0);
        done_i     = 8 * hb.size();
        nstrobe    = und ? nb + 1 : nb;
        ptr        = 0;
        first_done = -1;

        frame_start  = 1'b1;
        master_frame = v.master;
        @(posedge clk);
        #1;
        frame_start  = 1'b0;
        master_frame = 1'($urandom);

        for (int i = 0; i <= done_i + 1; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (v.rst_at >= 0 && i == v.rst_at) begin
                rst = 1'b1;
                for (int c = 0; c < 20; c++) begin
                    chk({v.name, "_rst"}, i + c, outs(), 6'b0);
                    @(posedge clk);
                    #1;
                end
                return;
            end
            sidx   = i - 143;
            is_str = (sidx >= 0) && (sidx % 16 == 0) && (sidx / 16 < nstrobe);
            e[5] = (i < done_i);
            e[4] = (i < done_i) ? hb[i/8] : 1'b0;
            e[3] = is_str;
            e[2] = (i == done_i);
            e[1] = (i <= done_i);
            e[0] = und && (i > 143 + 16 * nb);
            chk(v.name, i, outs(), e);
            if (frame_done === 1'b1 && first_done < 0) first_done = i;

            frame_start = (i == v.pulse_at - 1);
            if (is_str) begin
                bit_valid = (ptr < v.avail);
                bit_data  = (ptr < v.n) ? v.d[v.n-1-ptr] : 1'b0;
                bit_last  = (ptr == v.n - 1);
                if (ptr < v.avail) ptr++;
            end else begin
                bit_valid = 1'($urandom);
                bit_data  = 1'($urandom);
                bit_last  = 1'($urandom);
            end
            if (v.rst_at >= 0 && i == v.rst_at - 1) rst = 1'b0;
        end
        if (v.exp_done > 0) begin
            checks++;
            if (first_done + 1 != v.exp_done) begin
                failures++;
                $display("FAIL %s_done_time got=T+%0d want=T+%0d",
                         v.name, first_done + 1, v.exp_done);
            end
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 16, 32'hA5C3, 16, -1, -1, 417, "master16"};
        vecs[1] = '{1'b0, 1, 32'h1, 1, -1, -1, 177, "slave1"};
        vecs[2] = '{1'b1, 16, 32'hA5C3, 4, -1, -1, 225, "underrun4"};
        vecs[3] = '{1'b1, 16, 32'hA5C3, 16, 50, -1, 417, "ignore_start"};
        vecs[4] = '{1'b1, 4, 32'h9, 0, -1, -1, 161, "zero_data"};
        vecs[5] = '{1'b1, 16, 32'hA5C3, 16, -1, 200, 0, "mid_reset"};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset", 0, outs(), 6'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("idle", 0, outs(), 6'b0);

        for (int r = 0; r < 6; r++) begin
            run_frame(vecs[r]);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        for (int r = 0; r < 8; r++) begin
            vec_t v;
            v.master   = 1'($urandom);
            v.n        = $urandom_range(1, 24);
            v.d        = $urandom;
            v.avail    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, v.n - 1) : v.n;
            v.pulse_at = ($urandom_range(0, 1) == 0) ? $urandom_range(2, 150) : -1;
            v.rst_at   = -1;
            v.exp_done = 1 + 8 * (20 + 2 * ((v.avail < v.n) ? v.avail : v.n));
            v.name     = "random";
            run_frame(v);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
